arm_multicycle_ctrl: RTL and testbench
======================================

Name: arm_multicycle_ctrl

Overview:
- Multicycle sequencing controller for the ARMv4-subset core. It replaces the single-cycle decoder/condlogic pair.
- Latches nothing from memory itself. It reads Instr[31:12] from the instruction register and ALUFlags from the shared ALU.
- Issues per-state datapath controls so that one ALU and one unified memory are reused across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Owns the NZCV flag register and the condition check.

Parameters:
STATE_W, 4, width of State debug output (fixed encoding below; not to be reduced)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
Instr  in  20  IR bits [31:12]: cond, op, funct, Rd
ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
PCWrite  out  1  load PC register
AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  load instruction register
ResultSrc  out  2  00=ALUOut, 01=Data reg, 10=ALUResult
ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR
ALUSrcA  out  1  0=register A, 1=PC
ALUSrcB  out  2  00=WriteData reg, 01=ExtImm, 10=constant 4
ImmSrc  out  2  00 imm8, 01 imm12, 10 branch imm24
RegSrc  out  2  [0]: RA1=R15; [1]: RA2=Rd
RegWrite  out  1  register file write
MovFlag  out  1  ALU result mux selects SrcB (MOV)
Flags  out  4  current NZCV register
State  out  4  current FSM state

Behaviour:
- Clocking and reset: all state updates on posedge clk. While reset=1 at the edge: State<=FETCH(0), Flags<=0000.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9. Codes 10-15 go to FETCH next cycle with all strobes 0.
- Defaults: every output is 0 unless listed for the state.
- Outputs are combinational from State, Instr, Flags and ALUFlags. Immediately after reset (FETCH): IRWrite=1, PCWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10; all other strobes 0.
- Decode fields: Op=Instr[27:26], Funct=Instr[25:20], Rd=Instr[15:12], Cond=Instr[31:28].
  - ImmSrc = Op (00/01/10) in every state.
  - RegSrc[0] = (Op==10).
  - RegSrc[1] = (Op==01 & ~Funct[0]).
- States and transitions:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=000, ResultSrc=10, PCWrite=1 (unconditional) -> DECODE.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (forms PC+8). Next state by Op/Funct:
    - Op=01 -> MEMADR
    - Op=00 & ~Funct[5] -> EXECUTER
    - Op=00 & Funct[5] -> EXECUTEI
    - Op=10 -> BRANCH
    - Op=11 -> FETCH (NOP)
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=000 -> MEMREAD if Funct[0], else MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00 -> MEMWB.
  - MEMWB: ResultSrc=01, RegW=1 -> FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1 -> FETCH.
  - EXECUTER / EXECUTEI: ALUSrcA=0, ALUSrcB=00 / 01, ALU decode active -> ALUWB.
  - ALUWB: ResultSrc=00, RegW=1 -> FETCH.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ALUControl=000, ResultSrc=10, Branch=1 -> FETCH.
- ALU decode on Funct[4:1] (EXECUTER/EXECUTEI only):
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
  - 1101 MOV: ALUControl=000, MovFlag=CondEx.
  - Any other value: ALUControl=000, no register or flag write (the instruction is treated as a NOP, RegW suppressed in ALUWB).
  - Outside EXECUTE states, ALUControl=000.
- Condition check:
  - CondEx is computed from the registered Flags with the standard ARM table EQ..AL.
  - Cond=1111 gives CondEx=0.
- Gated strobes:
  - RegWrite = RegW & CondEx.
  - MemWrite = MemW & CondEx.
  - PCWrite = FETCH | (PCS & CondEx), where PCS = Branch | (ALUWB & Rd==15 & RegW).
  - A failed condition still walks the full state sequence; only the strobes are suppressed.
- Flag update: at the end of EXECUTER/EXECUTEI, when Funct[0]=1 and CondEx=1:
  - N,Z <= ALUFlags[3:2].
  - C,V <= ALUFlags[1:0] only for ADD/SUB.
  - MOV and logical ops keep C,V.
  - The new flags are visible from the following cycle (ALUWB onward). CondEx for the same instruction uses the old flags throughout.
- Latencies: B = 3 cycles; data-processing = 4; STR = 4; LDR = 5; Op=11 = 2.
- Reset mid-instruction: the next state is FETCH and Flags are cleared, regardless of the current state. No strobe other than the FETCH set is asserted in the cycle after the reset edge.

Test Plan:
1. Assert reset 2 cycles, release -> State=0, Flags=0000, IRWrite=1, PCWrite=1, MemWrite=0, RegWrite=0; the next cycle State=1.
2. Instr=E2802005 (ADD r2,r0,#5) -> State sequence 0,1,7,8,0; ALUSrcB=01 in 7; RegWrite=1 only in 8; Flags unchanged.
3. Instr=E5902000 (LDR) -> States 0,1,2,3,4,0; AdrSrc=1 in 3; RegWrite=1 with ResultSrc=01 in 4. Instr=E5802000 (STR) -> States 0,1,2,5,0; MemWrite=1 only in 5.
4. Instr=E0500000 (SUBS) with ALUFlags=0110 in state 6 -> Flags=0110 from state 8 onward. Then Instr=0A000002 (BEQ) -> PCWrite=1 in BRANCH. Instr=1A000002 (BNE) -> PCWrite=0 in BRANCH.
5. Flags Z=0, Instr=02802005 (ADDEQ) -> full sequence 0,1,7,8 with RegWrite=0. Instr=E1B02001 (MOVS) with ALUFlags=1011 -> MovFlag=1 in 6; Flags become 1000 (C,V kept 00).
6. Assert reset while in MEMWRITE (STR) -> MemWrite deasserted the next cycle, State=0, Flags=0000; a following ADD completes normally.

Source files
------------

// File: rtl/arm_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle sequencer and the shared datapath.
// Sequencer drives the strobes; the datapath supplies IR fields and live ALU flags.
interface arm_multicycle_ctrl_if #(
    parameter int STATE_W = 4
);
    logic [19:0]        Instr;
    logic [3:0]         ALUFlags;
    logic               PCWrite;
    logic               AdrSrc;
    logic               MemWrite;
    logic               IRWrite;
    logic [1:0]         ResultSrc;
    logic [2:0]         ALUControl;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ImmSrc;
    logic [1:0]         RegSrc;
    logic               RegWrite;
    logic               MovFlag;
    logic [3:0]         Flags;
    logic [STATE_W-1:0] State;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, RegWrite, MovFlag, Flags, State
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, RegWrite, MovFlag, Flags, State
    );
endinterface

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARMv4-subset sequencer with NZCV register; B=3, DP/STR=4, LDR=5, NOP=2 cycles.
// Outputs are combinational from state/IR/flags; no stall input, one instruction in flight.
module arm_multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    arm_multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] flags, flags_nxt;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       unused_rn;

    assign cond      = bus.Instr[19:16];
    assign op        = bus.Instr[15:14];
    assign funct     = bus.Instr[13:8];
    assign rd        = bus.Instr[3:0];
    assign unused_rn = ^bus.Instr[7:4];

    logic n_f, z_f, c_f, v_f, cond_ex;
    assign {n_f, z_f, c_f, v_f} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'h0: cond_ex = z_f;
            4'h1: cond_ex = ~z_f;
            4'h2: cond_ex = c_f;
            4'h3: cond_ex = ~c_f;
            4'h4: cond_ex = n_f;
            4'h5: cond_ex = ~n_f;
            4'h6: cond_ex = v_f;
            4'h7: cond_ex = ~v_f;
            4'h8: cond_ex = c_f & ~z_f;
            4'h9: cond_ex = ~c_f | z_f;
            4'hA: cond_ex = (n_f == v_f);
            4'hB: cond_ex = (n_f != v_f);
            4'hC: cond_ex = ~z_f & (n_f == v_f);
            4'hD: cond_ex = z_f | (n_f != v_f);
            4'hE: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Unrecognised data-processing commands decay to a NOP: no register or flag write.
    logic [2:0] alu_ctl;
    logic       alu_valid, alu_arith, alu_mov;

    always_comb begin
        alu_ctl   = 3'b000;
        alu_valid = 1'b1;
        alu_arith = 1'b0;
        alu_mov   = 1'b0;
        case (funct[4:1])
            4'b0100: alu_arith = 1'b1;
            4'b0010: begin alu_ctl = 3'b001; alu_arith = 1'b1; end
            4'b0000: alu_ctl = 3'b010;
            4'b1100: alu_ctl = 3'b011;
            4'b1101: alu_mov = 1'b1;
            default: alu_valid = 1'b0;
        endcase
    end

    logic reg_w, mem_w, branch, pc_fetch, in_aluwb;

    always_comb begin
        state_nxt      = FETCH;
        flags_nxt      = flags;
        reg_w          = 1'b0;
        mem_w          = 1'b0;
        branch         = 1'b0;
        pc_fetch       = 1'b0;
        in_aluwb       = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.ResultSrc  = 2'b00;
        bus.ALUControl = 3'b000;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.MovFlag    = 1'b0;
        case (state)
            FETCH: begin
                bus.IRWrite   = 1'b1;
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                pc_fetch      = 1'b1;
                state_nxt     = DECODE;
            end
            DECODE: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                case (op)
                    2'b00:   state_nxt = funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_nxt = MEMADR;
                    2'b10:   state_nxt = BRANCH;
                    default: state_nxt = FETCH;
                endcase
            end
            MEMADR: begin
                bus.ALUSrcB = 2'b01;
                state_nxt   = funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                bus.AdrSrc = 1'b1;
                state_nxt  = MEMWB;
            end
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                reg_w         = 1'b1;
            end
            MEMWRITE: begin
                bus.AdrSrc = 1'b1;
                mem_w      = 1'b1;
            end
            EXECUTER, EXECUTEI: begin
                bus.ALUSrcB    = (state == EXECUTEI) ? 2'b01 : 2'b00;
                bus.ALUControl = alu_ctl;
                bus.MovFlag    = alu_mov & cond_ex;
                state_nxt      = ALUWB;
                // Flags land at this edge; the instruction's own condition used the old ones.
                if (funct[0] && cond_ex && alu_valid) begin
                    flags_nxt[3:2] = bus.ALUFlags[3:2];
                    if (alu_arith)
                        flags_nxt[1:0] = bus.ALUFlags[1:0];
                end
            end
            ALUWB: begin
                reg_w    = alu_valid;
                in_aluwb = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                branch        = 1'b1;
            end
            default: state_nxt = FETCH;
        endcase
    end

    assign bus.ImmSrc   = op;
    assign bus.RegSrc   = {(op == 2'b01) & ~funct[0], (op == 2'b10)};
    assign bus.RegWrite = reg_w & cond_ex;
    assign bus.MemWrite = mem_w & cond_ex;
    assign bus.PCWrite  = pc_fetch | ((branch | (in_aluwb & (rd == 4'hF) & reg_w)) & cond_ex);
    assign bus.Flags    = flags;
    assign bus.State    = STATE_W'(state);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            flags <= 4'b0000;
        end else begin
            state <= state_nxt;
            flags <= flags_nxt;
        end
    end
endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Directed plus randomized instruction stream checked against an instruction-level model.
module tb_arm_multicycle_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    arm_multicycle_ctrl_if bus();
    arm_multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic       pcw, adr, memw, irw;
        logic [1:0] res;
        logic [2:0] aluc;
        logic       srca;
        logic [1:0] srcb, imm, regsrc;
        logic       regw, mov;
    } ctl_t;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [3:0] mflags = 4'b0000;
    logic [3:0] cmds [5] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1101};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        if (c == 4'hF) return 1'b0;
        if (c == 4'hE) return 1'b1;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf && !z;
            3'd5:    base = (n == v);
            default: base = !z && (n == v);
        endcase
        return c[0] ? !base : base;
    endfunction

    // Data-processing command meaning: {recognised, updates C/V, is MOV, ALU opcode}
    function automatic logic [5:0] dp_info(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return {1'b1, 1'b1, 1'b0, 3'b000};
            4'b0010: return {1'b1, 1'b1, 1'b0, 3'b001};
            4'b0000: return {1'b1, 1'b0, 1'b0, 3'b010};
            4'b1100: return {1'b1, 1'b0, 1'b0, 3'b011};
            4'b1101: return {1'b1, 1'b0, 1'b1, 3'b000};
            default: return 6'b0;
        endcase
    endfunction

    // Datapath routing that each step needs regardless of the instruction's outcome.
    function automatic ctl_t step_routing(input int st);
        ctl_t e = '0;
        case (st)
            0:       begin e.irw = 1; e.srca = 1; e.srcb = 2'b10; e.res = 2'b10; end
            1:       begin e.srca = 1; e.srcb = 2'b10; e.res = 2'b10; end
            2, 7:    e.srcb = 2'b01;
            3, 5:    e.adr = 1;
            4:       e.res = 2'b01;
            9:       begin e.srcb = 2'b01; e.res = 2'b10; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic ctl_t expect_ctl(input int st, input logic [31:0] ins, input logic [3:0] f);
        ctl_t       e    = step_routing(st);
        logic [5:0] info = dp_info(ins[24:21]);
        logic       ok   = cond_pass(ins[31:28], f);
        logic [1:0] op   = ins[27:26];
        e.imm    = op;
        e.regsrc = {op == 2'b01 && !ins[20], op == 2'b10};
        if (st == 6 || st == 7) begin
            e.aluc = info[2:0];
            e.mov  = info[3] && ok;
        end
        e.regw = ok && (st == 4 || (st == 8 && info[5]));
        e.memw = ok && st == 5;
        e.pcw  = (st == 0) || (ok && (st == 9 || (st == 8 && info[5] && ins[15:12] == 4'hF)));
        return e;
    endfunction

    function automatic ctl_t observed_ctl();
        ctl_t o;
        o.pcw = bus.PCWrite;   o.adr = bus.AdrSrc;     o.memw = bus.MemWrite; o.irw = bus.IRWrite;
        o.res = bus.ResultSrc; o.aluc = bus.ALUControl; o.srca = bus.ALUSrcA;  o.srcb = bus.ALUSrcB;
        o.imm = bus.ImmSrc;    o.regsrc = bus.RegSrc;  o.regw = bus.RegWrite; o.mov = bus.MovFlag;
        return o;
    endfunction

    task automatic check_after_reset(input string tag);
        chk({tag, ".state"}, 32'(bus.State), 32'd0);
        chk({tag, ".flags"}, 32'(bus.Flags), 32'd0);
        chk({tag, ".memwrite"}, 32'(bus.MemWrite), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mflags = 4'b0000;
        check_after_reset("reset");
    endtask

    // Called at posedge+1 of a FETCH cycle; returns at posedge+1 of the next FETCH.
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] alu, input int abort_at);
        int         seq[$];
        logic [5:0] fn   = ins[25:20];
        logic [5:0] info = dp_info(ins[24:21]);
        logic       ok;
        seq = {0, 1};
        case (ins[27:26])
            2'b00:   begin seq.push_back(fn[5] ? 7 : 6); seq.push_back(8); end
            2'b01:   begin seq.push_back(2); if (fn[0]) seq = {seq, 3, 4}; else seq.push_back(5); end
            2'b10:   seq.push_back(9);
            default: ;
        endcase
        bus.Instr    = ins[31:12];
        bus.ALUFlags = alu;
        foreach (seq[i]) begin
            @(negedge clk);
            ok = cond_pass(ins[31:28], mflags);
            chk($sformatf("%h.step%0d.state", ins, i), 32'(bus.State), 32'(seq[i]));
            chk($sformatf("%h.step%0d.flags", ins, i), 32'(bus.Flags), 32'(mflags));
            chk($sformatf("%h.step%0d.ctl", ins, i), 32'(observed_ctl()),
                32'(expect_ctl(seq[i], ins, mflags)));
            if (i == abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset  = 1'b0;
                mflags = 4'b0000;
                check_after_reset("abort");
                return;
            end
            if ((seq[i] == 6 || seq[i] == 7) && fn[0] && ok && info[5])
                mflags = {alu[3:2], info[4] ? alu[1:0] : mflags[1:0]};
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] ins;
        logic [3:0]  cnd, cmd;
        reset        = 1'b1;
        bus.Instr    = '0;
        bus.ALUFlags = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_after_reset("por");

        run_instr(32'hE280_2005, 4'b1111, -1);  // ADD imm
        run_instr(32'hE590_2000, 4'b0000, -1);  // LDR
        run_instr(32'hE580_2000, 4'b0000, -1);  // STR
        run_instr(32'hE050_0000, 4'b0110, -1);  // SUBS -> Z,C set
        chk("subs.flags", 32'(bus.Flags), 32'h6);
        run_instr(32'h0A00_0002, 4'b0000, -1);  // BEQ taken
        run_instr(32'h1A00_0002, 4'b0000, -1);  // BNE not taken
        run_instr(32'hEC00_0000, 4'b0000, -1);  // Op=11 NOP
        run_instr(32'hE280_F008, 4'b0000, -1);  // ADD to PC
        run_instr(32'hE2B0_2005, 4'b1111, -1);  // unknown cmd, S set: no effect
        do_reset();
        run_instr(32'h0280_2005, 4'b0000, -1);  // ADDEQ, Z=0
        run_instr(32'hE1B0_2001, 4'b1011, -1);  // MOVS
        chk("movs.flags", 32'(bus.Flags), 32'h8);
        run_instr(32'hE580_2000, 4'b0000, 3);   // STR, reset in MEMWRITE
        run_instr(32'hE280_2005, 4'b0000, -1);

        for (int k = 0; k < 200; k++) begin
            cnd = ($urandom_range(2) == 0) ? 4'hE : 4'($urandom_range(15));
            cmd = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : cmds[$urandom_range(4)];
            ins = $urandom;
            ins[31:28] = cnd;
            ins[24:21] = cmd;
            if ($urandom_range(7) == 0) ins[15:12] = 4'hF;
            if ($urandom_range(30) == 0) do_reset();
            run_instr(ins, 4'($urandom_range(15)), ($urandom_range(25) == 0) ? 2 : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
